// File: rtl/io_display_port.sv
// Bus snooper for the urisc/mem bus: captures CPU writes to IO_ADDR into a small FIFO and
// presents each byte on a 16-bit display word, {seq, byte}, for HOLD_CYCLES clocks.
module io_display_port #(
  parameter logic [7:0]  IO_ADDR     = 8'hFF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [15:0] disp,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [CntW-1:0]   DepthCnt  = CntW'(DEPTH);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(HOLD_CYCLES - 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       disp_q, disp_d;
  logic              ovf_q, ovf_d;

  logic capture;
  logic pop;
  logic push;

  // Capture qualification; a full FIFO still accepts when a pop frees a slot on the same edge.
  always_comb begin
    capture = we && (addr == IO_ADDR);
    pop     = (state_q == StIdle) && (count_q != '0);
    push    = capture && ((count_q != DepthCnt) || pop);
  end

  // FIFO pointer/occupancy bookkeeping and the sticky drop flag.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (capture && !push) begin
      ovf_d = 1'b1;
    end
  end

  // Display FSM: IDLE pops the head onto disp, SHOW counts the hold time down to zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    disp_d  = disp_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          seq_d   = seq_q + 8'd1;
          disp_d  = {seq_d, mem_q[head_q]};
          timer_d = TimerLoad;
          state_d = StShow;
        end
      end
      StShow: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and display state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      seq_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[tail_q] <= wdata;
    end
  end

  // Output drive.
  always_comb begin
    disp      = disp_q;
    busy      = (state_q == StShow);
    fifo_full = (count_q == DepthCnt);
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_io_display_port.sv
// Randomised and directed bench for io_display_port against a queue-based display model.
module tb_io_display_port;

  localparam int unsigned Hold   = 4;
  localparam int unsigned Depth  = 4;
  localparam logic [7:0]  IoAddr = 8'hFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        we;
  logic [15:0] disp;
  logic        busy;
  logic        fifo_full;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  io_display_port #(
    .IO_ADDR    (IoAddr),
    .DEPTH      (Depth),
    .HOLD_CYCLES(Hold)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .disp     (disp),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: pending bytes in a queue, plus how many hold cycles remain for the shown byte.
  byte unsigned q[$];
  logic [15:0]  m_disp;
  logic [7:0]   m_seq;
  int           m_left;
  logic         m_ovf;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    q.delete();
    m_disp = 16'h0000;
    m_seq  = 8'h00;
    m_left = 0;
    m_ovf  = 1'b0;
  endtask

  task model_step();
    bit pop;
    bit req;
    pop = (m_left == 0) && (q.size() > 0);
    req = we && (addr == IoAddr);
    if (m_left > 0) m_left--;
    if (pop) begin
      m_seq  = m_seq + 8'd1;
      m_disp = {m_seq, q.pop_front()};
      m_left = Hold;
    end
    if (req) begin
      if (q.size() < Depth) q.push_back(wdata);
      else m_ovf = 1'b1;
    end
  endtask

  task compare_all();
    check("disp", disp, m_disp);
    check("busy", 16'(busy), 16'(m_left > 0));
    check("fifo_full", 16'(fifo_full), 16'(q.size() == Depth));
    check("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) compare_all();
  end

  task automatic write_io(input logic [7:0] d, input logic [7:0] a);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit got;
    logic [15:0] prev;
    logic [7:0] b;

    reset = 1'b1; we = 1'b0; addr = 8'h00; wdata = 8'h00;
    #12;
    check("rst_disp", disp, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_full", 16'(fifo_full), 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Non-matching addresses are ignored.
    write_io(8'hAA, 8'hFE);
    write_io(8'h55, 8'h00);
    repeat (3) @(negedge clk);
    check("ign_disp", disp, 16'h0000);
    check("ign_ovf", 16'(overflow), 16'h0);

    // Single byte: shown one edge after capture, held for Hold cycles.
    write_io(8'h3C, IoAddr);
    @(negedge clk);
    check("single_disp", disp, 16'h013C);
    check("single_busy0", 16'(busy), 16'h1);
    repeat (3) begin
      @(negedge clk);
      check("single_busy", 16'(busy), 16'h1);
    end
    @(negedge clk);
    check("single_idle", 16'(busy), 16'h0);
    repeat (5) @(negedge clk);
    check("single_persist", disp, 16'h013C);

    // Six back-to-back writes: fill, drop the sixth, step every Hold+1 cycles.
    reset_dut();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      we = 1'b1; addr = IoAddr; wdata = 8'(i);
    end
    @(negedge clk);
    we = 1'b0;
    check("six_full", 16'(fifo_full), 16'h1);
    check("six_ovf", 16'(overflow), 16'h1);
    check("six_first", disp, 16'h0101);
    prev = disp;
    for (int k = 2; k <= 5; k++) begin
      got = 1'b0;
      gap = 0;
      for (int c = 1; c <= 10 && !got; c++) begin
        @(negedge clk);
        if (disp !== prev) begin
          got = 1'b1;
          gap = c;
        end
      end
      check("six_step_val", disp, {8'(k), 8'(k)});
      if (k > 2) check("six_step_gap", 16'(gap), 16'd5);
      prev = disp;
    end
    repeat (20) @(negedge clk);
    check("six_no_06", disp, 16'h0505);
    check("six_ovf_sticky", 16'(overflow), 16'h1);

    // Full FIFO accepts a write on the same edge as a pop.
    reset_dut();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      we = 1'b1; addr = IoAddr; wdata = 8'(i);
    end
    @(negedge clk);
    we = 1'b0;
    check("fp_full", 16'(fifo_full), 16'h1);
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    check("fp_wait_idle", 16'(busy), 16'h0);
    we = 1'b1; addr = IoAddr; wdata = 8'h77;
    @(negedge clk);
    we = 1'b0;
    check("fp_still_full", 16'(fifo_full), 16'h1);
    check("fp_no_ovf", 16'(overflow), 16'h0);
    check("fp_disp", disp, 16'h0202);

    // 256 spaced writes: sequence number wraps to 00 on the last one.
    reset_dut();
    b = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      b = 8'(i) ^ 8'h5A;
      write_io(b, IoAddr);
      if (i == 1) begin
        @(negedge clk);
        check("wrap_first", disp, {8'h01, b});
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    check("wrap_last", disp, {8'h00, b});
    check("wrap_ovf", 16'(overflow), 16'h0);

    // Asynchronous reset mid-hold with three bytes pending.
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      we = 1'b1; addr = IoAddr; wdata = 8'(8'h10 + i);
    end
    @(negedge clk);
    we = 1'b0;
    check("mid_busy", 16'(busy), 16'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_disp", disp, 16'h0000);
    check("mid_busy0", 16'(busy), 16'h0);
    check("mid_full0", 16'(fifo_full), 16'h0);
    check("mid_ovf0", 16'(overflow), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    write_io(8'h42, IoAddr);
    @(negedge clk);
    check("mid_after", disp, 16'h0142);

    // Random traffic, including overflow and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      we    = ($urandom_range(0, 2) == 0);
      addr  = ($urandom_range(0, 2) != 0) ? IoAddr : 8'($urandom);
      wdata = 8'($urandom);
    end
    @(negedge clk);
    we = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
